// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    REL_WAIT   = 2'd1,
    PRS_STABLE = 2'd2,
    PRS_WAIT   = 2'd3
  } db_state_e;

  // 1 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/key_debounce_sync2.sv
// Two-flop synchronizer; reset value selects the idle level of the pin.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer: synchronize, require DEBOUNCE_CYCLES agreeing samples,
// then report a registered level plus one-cycle press/release pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic              REL_RAW  = KEY_ACTIVE_LOW;

  logic              raw_s;
  logic              pressed;
  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, press_q, release_q;
  logic              press_d, release_d;

  sync2 #(.RST_VAL(REL_RAW)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (key_raw),
    .q_o   (raw_s)
  );

  assign pressed = KEY_ACTIVE_LOW ? ~raw_s : raw_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      REL_STABLE: if (pressed) begin
        state_d = REL_WAIT;
        cnt_d   = CNT_ONE;
      end
      REL_WAIT: begin
        if (!pressed) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS_STABLE: if (!pressed) begin
        state_d = PRS_WAIT;
        cnt_d   = CNT_ONE;
      end
      PRS_WAIT: begin
        if (pressed) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = REL_STABLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= REL_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= (state_d == PRS_STABLE) || (state_d == PRS_WAIT);
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (DEBOUNCE_CYCLES=4, active-low key): expected pulses
// are queued with their edge number and matched as the DUT emits them.
module tb_key_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_raw = 1'b1;
  logic key_level, key_press, key_release;

  key_debounce #(.DEBOUNCE_CYCLES(N), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    bit is_press;
    int edge_at;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  qeff_cnt = 0;
  logic qin_d = 1'b0;
  int  last_pulse = -1000;

  // Pulse monitor plus a model of the downstream single-pulse stage (Qin -> Qeff).
  always @(negedge clk) begin
    if (rst) begin
      if (key_press && !qin_d) qeff_cnt++;
      if (key_press || key_release) begin
        tests++;
        if (key_press && key_release) begin
          fails++;
          $display("FAIL pulse_excl: press=1 release=1 at edge %0d, want at most one", edge_n);
        end else if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: press=%0b release=%0b at edge %0d, want none", key_press, key_release, edge_n);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_press !== key_press || mon_e.edge_at !== edge_n) begin
            fails++;
            $display("FAIL pulse_match: got press=%0b at edge %0d, want press=%0b at edge %0d",
                     key_press, edge_n, mon_e.is_press, mon_e.edge_at);
          end
        end
        tests++;
        if (edge_n - last_pulse < N) begin
          fails++;
          $display("FAIL pulse_spacing: got %0d cycles, want >= %0d", edge_n - last_pulse, N);
        end
        last_pulse = edge_n;
      end
    end
    qin_d = key_press;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_raw = 1'b1;
    tick(2);
    tests++;
    if ({key_level, key_press, key_release} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outs: got %b, want 000", {key_level, key_press, key_release});
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      tests++;
      if ({key_level, key_press, key_release} !== 3'b000) begin
        fails++;
        $display("FAIL idle_outs: cycle %0d got %b, want 000", i, {key_level, key_press, key_release});
      end
    end
  endtask

  task automatic test_press();
    int base;
    key_raw = 1'b0;
    base = edge_n;
    sb.push_back('{1'b1, base + N + 2});
    for (int i = 0; i < N + 4; i++) begin
      tick(1);
      tests++;
      if (key_level !== (edge_n >= base + N + 2)) begin
        fails++;
        $display("FAIL press_level: edge %0d got %0b, want %0b", edge_n - base, key_level, edge_n >= base + N + 2);
      end
      tests++;
      if (key_press !== (edge_n == base + N + 2)) begin
        fails++;
        $display("FAIL press_pulse: edge %0d got %0b, want %0b", edge_n - base, key_press, edge_n == base + N + 2);
      end
    end
    tick(12);
    drain(20);
    tests++;
    if (sb.size() !== 0 || key_level !== 1'b1) begin
      fails++;
      $display("FAIL press_hold: pending=%0d level=%0b, want pending=0 level=1", sb.size(), key_level);
      sb.delete();
    end
  endtask

  task automatic test_bounce_release();
    int base;
    key_raw = 1'b1;
    base = edge_n;
    tick(1);
    key_raw = 1'b0;
    tick(1);
    key_raw = 1'b1;
    sb.push_back('{1'b0, base + N + 4});
    while (edge_n < base + N + 7) begin
      tick(1);
      tests++;
      if (key_level !== (edge_n < base + N + 4)) begin
        fails++;
        $display("FAIL bounce_level: edge %0d got %0b, want %0b", edge_n - base, key_level, edge_n < base + N + 4);
      end
    end
    drain(20);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL bounce_release: %0d pulse(s) missing, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    key_raw = 1'b0;
    tick(N - 1);
    key_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      tests++;
      if (key_level !== 1'b0) begin
        fails++;
        $display("FAIL glitch_level: cycle %0d got %0b, want 0", i, key_level);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    key_raw = 1'b0;
    tick(4);
    rst = 1'b0;
    #1;
    tests++;
    if ({key_level, key_press, key_release} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_outs: got %b, want 000", {key_level, key_press, key_release});
    end
    tick(2);
    rst = 1'b1;
    base = edge_n;
    sb.push_back('{1'b1, base + N + 2});
    for (int i = 0; i < N + 3; i++) begin
      tick(1);
      tests++;
      if (key_level !== (edge_n >= base + N + 2)) begin
        fails++;
        $display("FAIL rst_held_level: edge %0d got %0b, want %0b", edge_n - base, key_level, edge_n >= base + N + 2);
      end
    end
    drain(20);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL rst_held_press: %0d pulse(s) missing, want 0", sb.size());
      sb.delete();
    end
    // Reset while pressed must drop the level without waiting for a clock.
    rst = 1'b0;
    #1;
    tests++;
    if (key_level !== 1'b0) begin
      fails++;
      $display("FAIL rst_async_level: got %0b, want 0", key_level);
    end
    key_raw = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(10);
    tests++;
    if ({key_level, key_press, key_release} !== 3'b000) begin
      fails++;
      $display("FAIL rst_after_outs: got %b, want 000", {key_level, key_press, key_release});
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = qeff_cnt;
    for (int i = 0; i < 3; i++) begin
      key_raw = 1'b0;
      sb.push_back('{1'b1, edge_n + N + 2});
      tick(N + 4);
      key_raw = 1'b1;
      sb.push_back('{1'b0, edge_n + N + 2});
      tick(N + 4);
    end
    drain(20);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL b2b_pending: %0d pulse(s) missing, want 0", sb.size());
      sb.delete();
    end
    tests++;
    if (qeff_cnt - start !== 3) begin
      fails++;
      $display("FAIL qeff_count: got %0d, want 3", qeff_cnt - start);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce_release();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 50000 and give the number of consecutive agreeing samples needed to accept a level change (1 ms at 50 MHz); legal range is >= 2.
REQ-003 Parameter KEY_ACTIVE_LOW SHALL default to 1; 1 means raw 0 = pressed (board KEYs), 0 means raw 1 = pressed.
REQ-004 clk  in  1  sole clock; all flops on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset; asserted at 0.
REQ-006 key_raw  in  1  unsynchronized pushbutton pin, asynchronous to clk.
REQ-007 key_level  out  1  debounced pressed level (1 = pressed), registered.
REQ-008 key_press  out  1  one-cycle pulse per accepted press; drives the downstream single-pulse stage input Qin.
REQ-009 key_release  out  1  one-cycle pulse per accepted release.

Function
REQ-010 key_raw SHALL pass through a two-flop synchronizer; the second flop output is normalized to "pressed" per KEY_ACTIVE_LOW before any other use.
REQ-011 The FSM SHALL have four states: REL_STABLE, REL_WAIT, PRS_STABLE, PRS_WAIT.
REQ-012 REL_STABLE: a pressed sample SHALL go to REL_WAIT with count=1; otherwise the FSM stays.
REQ-013 REL_WAIT: a released sample SHALL go to REL_STABLE and clear the count; a pressed sample with count==DEBOUNCE_CYCLES-1 SHALL go to PRS_STABLE; any other pressed sample SHALL increment the count.
REQ-014 PRS_STABLE and PRS_WAIT SHALL mirror REQ-012/013 with pressed and released swapped; completing PRS_WAIT SHALL go to REL_STABLE.
REQ-015 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the count never wraps and saturates at DEBOUNCE_CYCLES-1 by construction.
REQ-016 key_level SHALL be 1 exactly in PRS_STABLE and PRS_WAIT.
REQ-017 key_press SHALL be a registered pulse, high for exactly the one cycle following the REL_WAIT->PRS_STABLE edge.
REQ-018 key_release SHALL be a registered pulse, high for exactly the one cycle following the PRS_WAIT->REL_STABLE edge.
REQ-019 Latency SHALL be as follows: a clean input change before rising edge 1 is reflected on key_level/key_press after rising edge DEBOUNCE_CYCLES+2.
REQ-020 Glitches: any opposite-level run shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change and no pulse.
REQ-021 key_press and key_release SHALL never be high together, and consecutive pulses SHALL be separated by at least DEBOUNCE_CYCLES cycles.

Reset
REQ-022 Asserting rst SHALL immediately force REL_STABLE, count=0, key_level=0, key_press=0, key_release=0.
REQ-023 Asserting rst SHALL force both synchronizer flops to the released raw level: 1 if KEY_ACTIVE_LOW, else 0.
REQ-024 A key held through reset deassertion SHALL yield exactly one key_press, DEBOUNCE_CYCLES+2 edges after deassertion.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count and emit no pulse.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the state enum typedef (logic [1:0]) and the default DEBOUNCE_CYCLES constant.
REQ-027 Sub-module sync2 (two-flop synchronizer, parameterized reset value, async active-low reset) SHALL be instantiated once.
REQ-028 The FSM, counter and pulse registers SHALL live in key_debounce with no combinational input-to-output path.

Verification (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
REQ-029 Scenario: reset, then key_raw=1 for 20 cycles -> all outputs 0 throughout.
REQ-030 Scenario: key_raw 1->0 and held -> key_level=1 and key_press=1 after edge 6, key_press=0 after edge 7.
REQ-031 Scenario: key_raw low for 3 cycles, then high -> no key_press, key_level stays 0.
REQ-032 Scenario: from pressed, key_raw bounces 1,0,1,1,1,1 -> one key_release only after 4 consecutive released samples.
REQ-033 Scenario: rst pulsed low during REL_WAIT with count=2 -> outputs 0 immediately; after release with key still held, one key_press at edge 6.
REQ-034 Scenario: key_press chained into the single-pulse stage with 3 press/release cycles -> exactly 3 downstream Qeff pulses.
